multicycle_ctrl: RTL and testbench

MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

---
 rtl/mips_ctrl_pkg.sv | 36 +++
 rtl/mc_opdec.sv | 27 ++
 rtl/multicycle_ctrl.sv | 167 ++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/mips_ctrl_pkg.sv
// Shared types and constants for the multicycle MIPS control FSM:
// the 4-bit state encoding, primary opcodes and ALU operation selects.
package mips_ctrl_pkg;

    typedef enum logic [3:0] {
        FETCH   = 4'd0,
        DECODE  = 4'd1,
        MEMADR  = 4'd2,
        MEMRD   = 4'd3,
        MEMWB   = 4'd4,
        MEMWR   = 4'd5,
        EXECUTE = 4'd6,
        ALUWB   = 4'd7,
        BRANCH  = 4'd8,
        ADDIEX  = 4'd9,
        ADDIWB  = 4'd10,
        JUMP    = 4'd11,
        ORIEX   = 4'd12,
        ORIWB   = 4'd13
    } state_t;

    localparam logic [5:0] RTYPE = 6'b000000;
    localparam logic [5:0] LW    = 6'b100011;
    localparam logic [5:0] SW    = 6'b101011;
    localparam logic [5:0] BEQ   = 6'b000100;
    localparam logic [5:0] BNE   = 6'b000101;
    localparam logic [5:0] ADDI  = 6'b001000;
    localparam logic [5:0] J     = 6'b000010;
    localparam logic [5:0] ORI   = 6'b001101;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;
    localparam logic [1:0] ALUOP_OR    = 2'b11;

endpackage

// File: rtl/mc_opdec.sv
// Opcode decoder: maps the IR opcode to the state that follows DECODE.
// ORI is only recognised when MULTICYCLE_CTRL_ORI_EN is defined.
module mc_opdec
    import mips_ctrl_pkg::*;
(
    input  logic [5:0] op,
    output state_t     next_state,
    output logic       legal
);

    always_comb begin
        next_state = FETCH;
        legal      = 1'b1;
        case (op)
            RTYPE:   next_state = EXECUTE;
            LW, SW:  next_state = MEMADR;
            BEQ, BNE: next_state = BRANCH;
            ADDI:    next_state = ADDIEX;
            J:       next_state = JUMP;
`ifdef MULTICYCLE_CTRL_ORI_EN
            ORI:     next_state = ORIEX;
`endif
            default: legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Moore control FSM for a multicycle MIPS datapath. Optional ORI support
// is enabled by defining MULTICYCLE_CTRL_ORI_EN; otherwise zext is tied 0.
module multicycle_ctrl
    import mips_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic       mem_ready,
    output logic       pcwrite,
    output logic       branch,
    output logic       bne,
    output logic       iord,
    output logic       memwrite,
    output logic       irwrite,
    output logic       regdst,
    output logic       memtoreg,
    output logic       regwrite,
    output logic       alusrca,
    output logic       zext,
    output logic       instr_done,
    output logic       illegal_op,
    output logic [1:0] alusrcb,
    output logic [1:0] pcsrc,
    output logic [1:0] aluop,
    output logic [3:0] state
);

    state_t state_q, state_d;
    state_t dec_state;
    logic   dec_legal;

    mc_opdec u_opdec (
        .op         (op),
        .next_state (dec_state),
        .legal      (dec_legal)
    );

    always_ff @(posedge clk) begin
        if (reset) state_q <= FETCH;
        else       state_q <= state_d;
    end

    assign state = state_q;

`ifndef MULTICYCLE_CTRL_ORI_EN
    assign zext = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        pcwrite    = 1'b0;
        branch     = 1'b0;
        bne        = 1'b0;
        iord       = 1'b0;
        memwrite   = 1'b0;
        irwrite    = 1'b0;
        regdst     = 1'b0;
        memtoreg   = 1'b0;
        regwrite   = 1'b0;
        alusrca    = 1'b0;
        instr_done = 1'b0;
        illegal_op = 1'b0;
        alusrcb    = 2'b00;
        pcsrc      = 2'b00;
        aluop      = ALUOP_ADD;
`ifdef MULTICYCLE_CTRL_ORI_EN
        zext       = 1'b0;
`endif
        case (state_q)
            FETCH: begin
                alusrcb = 2'b01;
                irwrite = mem_ready;
                pcwrite = mem_ready;
                if (mem_ready) state_d = DECODE;
            end
            DECODE: begin
                alusrcb    = 2'b11;
                illegal_op = ~dec_legal;
                state_d    = dec_state;
            end
            MEMADR: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
                state_d = (op == LW) ? MEMRD : MEMWR;
            end
            MEMRD: begin
                iord = 1'b1;
                if (mem_ready) state_d = MEMWB;
            end
            MEMWB: begin
                memtoreg   = 1'b1;
                regwrite   = 1'b1;
                instr_done = 1'b1;
                state_d    = FETCH;
            end
            MEMWR: begin
                // Store completes only once memory accepts it.
                iord       = 1'b1;
                memwrite   = 1'b1;
                instr_done = mem_ready;
                if (mem_ready) state_d = FETCH;
            end
            EXECUTE: begin
                alusrca = 1'b1;
                aluop   = ALUOP_FUNCT;
                state_d = ALUWB;
            end
            ALUWB: begin
                regdst     = 1'b1;
                regwrite   = 1'b1;
                instr_done = 1'b1;
                state_d    = FETCH;
            end
            BRANCH: begin
                alusrca    = 1'b1;
                aluop      = ALUOP_SUB;
                pcsrc      = 2'b01;
                branch     = 1'b1;
                bne        = (op == BNE);
                instr_done = 1'b1;
                state_d    = FETCH;
            end
            ADDIEX: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
                state_d = ADDIWB;
            end
            ADDIWB: begin
                regwrite   = 1'b1;
                instr_done = 1'b1;
                state_d    = FETCH;
            end
            JUMP: begin
                pcsrc      = 2'b10;
                pcwrite    = 1'b1;
                instr_done = 1'b1;
                state_d    = FETCH;
            end
`ifdef MULTICYCLE_CTRL_ORI_EN
            ORIEX: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
                aluop   = ALUOP_OR;
                zext    = 1'b1;
                state_d = ORIWB;
            end
            ORIWB: begin
                regwrite   = 1'b1;
                instr_done = 1'b1;
                state_d    = FETCH;
            end
`endif
            default: state_d = FETCH;
        endcase
        // Reset suppresses every side effect, whatever state we are in.
        if (reset) begin
            pcwrite    = 1'b0;
            irwrite    = 1'b0;
            memwrite   = 1'b0;
            regwrite   = 1'b0;
            instr_done = 1'b0;
            illegal_op = 1'b0;
        end
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: directed per-cycle vectors with
// hand-computed expected outputs; a negedge monitor pops and compares.
module tb_multicycle_ctrl;
    import mips_ctrl_pkg::*;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [5:0] op = 6'd0;
    logic       mem_ready = 1'b1;
    logic       pcwrite, branch, bne, iord, memwrite, irwrite, regdst, memtoreg;
    logic       regwrite, alusrca, zext, instr_done, illegal_op;
    logic [1:0] alusrcb, pcsrc, aluop;
    logic [3:0] state;

    multicycle_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .op         (op),
        .mem_ready  (mem_ready),
        .pcwrite    (pcwrite),
        .branch     (branch),
        .bne        (bne),
        .iord       (iord),
        .memwrite   (memwrite),
        .irwrite    (irwrite),
        .regdst     (regdst),
        .memtoreg   (memtoreg),
        .regwrite   (regwrite),
        .alusrca    (alusrca),
        .zext       (zext),
        .instr_done (instr_done),
        .illegal_op (illegal_op),
        .alusrcb    (alusrcb),
        .pcsrc      (pcsrc),
        .aluop      (aluop),
        .state      (state)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         step;
        logic [3:0] st;
        logic [3:0] wen;   // pcwrite irwrite memwrite regwrite
        logic [8:0] flg;   // instr_done illegal_op branch bne iord regdst memtoreg alusrca zext
        logic [5:0] sel;   // alusrcb pcsrc aluop
    } exp_t;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;
    int   step_no = 0;

    task automatic cmp(input string name, input int stp, input logic [8:0] act, input logic [8:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL step %0d %s: got %b expected %b", stp, name, act, exp);
        end
    endtask

    // Monitor: compares whatever the stimulus side queued for this cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                cmp("state", e.step, {5'd0, state}, {5'd0, e.st});
                cmp("wen", e.step, {5'd0, pcwrite, irwrite, memwrite, regwrite}, {5'd0, e.wen});
                cmp("flags", e.step,
                    {instr_done, illegal_op, branch, bne, iord, regdst, memtoreg, alusrca, zext}, e.flg);
                cmp("sel", e.step, {3'd0, alusrcb, pcsrc, aluop}, {3'd0, e.sel});
                $display("[TB] step %0d rst=%0b op=%b mr=%0b state=%0d", e.step, reset, op, mem_ready, state);
            end
        end
    end

    task automatic step(input logic rst, input logic [5:0] o, input logic mr,
                        input state_t st, input logic [3:0] wen, input logic [8:0] flg,
                        input logic [5:0] sel);
        exp_t e;
        @(posedge clk);
        #1;
        reset     = rst;
        op        = o;
        mem_ready = mr;
        step_no++;
        e.step = step_no;
        e.st   = st;
        e.wen  = wen;
        e.flg  = flg;
        e.sel  = sel;
        sb.push_back(e);
    endtask

    task automatic fetch(input logic [5:0] o);
        step(1'b0, o, 1'b1, FETCH, 4'b1100, 9'b0, 6'b01_00_00);
    endtask

    task automatic decode(input logic [5:0] o);
        step(1'b0, o, 1'b1, DECODE, 4'b0000, 9'b0, 6'b11_00_00);
    endtask

    initial begin
        // First reset cycle: state is not yet defined, nothing queued.
        @(posedge clk);
        #1;
        reset = 1'b1;
        step(1'b1, RTYPE, 1'b1, FETCH, 4'b0000, 9'b0, 6'b01_00_00);

        // R-type: 4 cycles, done and write-back in cycle 4
        fetch(RTYPE);
        decode(RTYPE);
        step(1'b0, RTYPE, 1'b1, EXECUTE, 4'b0000, 9'b000000010, 6'b00_00_10);
        step(1'b0, RTYPE, 1'b1, ALUWB,   4'b0001, 9'b100001000, 6'b00_00_00);

        // lw with 3 wait cycles in MEMRD: 8 cycles total
        fetch(LW);
        decode(LW);
        step(1'b0, LW, 1'b1, MEMADR, 4'b0000, 9'b000000010, 6'b10_00_00);
        for (int i = 0; i < 3; i++)
            step(1'b0, LW, 1'b0, MEMRD, 4'b0000, 9'b000010000, 6'b00_00_00);
        step(1'b0, LW, 1'b1, MEMRD, 4'b0000, 9'b000010000, 6'b00_00_00);
        step(1'b0, LW, 1'b1, MEMWB, 4'b0001, 9'b100000100, 6'b00_00_00);

        // sw, memory ready immediately
        fetch(SW);
        decode(SW);
        step(1'b0, SW, 1'b1, MEMADR, 4'b0000, 9'b000000010, 6'b10_00_00);
        step(1'b0, SW, 1'b1, MEMWR,  4'b0010, 9'b100010000, 6'b00_00_00);

        // bne then beq
        fetch(BNE);
        decode(BNE);
        step(1'b0, BNE, 1'b1, BRANCH, 4'b0000, 9'b101100010, 6'b00_01_01);
        fetch(BEQ);
        decode(BEQ);
        step(1'b0, BEQ, 1'b1, BRANCH, 4'b0000, 9'b101000010, 6'b00_01_01);

        // j
        fetch(J);
        decode(J);
        step(1'b0, J, 1'b1, JUMP, 4'b1000, 9'b100000000, 6'b00_10_00);

        // addi
        fetch(ADDI);
        decode(ADDI);
        step(1'b0, ADDI, 1'b1, ADDIEX, 4'b0000, 9'b000000010, 6'b10_00_00);
        step(1'b0, ADDI, 1'b1, ADDIWB, 4'b0001, 9'b100000000, 6'b00_00_00);

        // illegal opcode returns straight to FETCH
        fetch(6'b111111);
        step(1'b0, 6'b111111, 1'b1, DECODE, 4'b0000, 9'b010000000, 6'b11_00_00);

        // ori, depending on build option
        fetch(ORI);
`ifdef MULTICYCLE_CTRL_ORI_EN
        decode(ORI);
        step(1'b0, ORI, 1'b1, ORIEX, 4'b0000, 9'b000000011, 6'b10_00_11);
        step(1'b0, ORI, 1'b1, ORIWB, 4'b0001, 9'b100000000, 6'b00_00_00);
`else
        step(1'b0, ORI, 1'b1, DECODE, 4'b0000, 9'b010000000, 6'b11_00_00);
`endif

        // FETCH holds while memory is not ready
        step(1'b0, J, 1'b0, FETCH, 4'b0000, 9'b0, 6'b01_00_00);
        step(1'b0, J, 1'b0, FETCH, 4'b0000, 9'b0, 6'b01_00_00);
        fetch(J);
        decode(J);
        step(1'b0, J, 1'b1, JUMP, 4'b1000, 9'b100000000, 6'b00_10_00);

        // reset while MEMWR waits: no write, no done, back to FETCH
        fetch(SW);
        decode(SW);
        step(1'b0, SW, 1'b1, MEMADR, 4'b0000, 9'b000000010, 6'b10_00_00);
        step(1'b0, SW, 1'b0, MEMWR,  4'b0010, 9'b000010000, 6'b00_00_00);
        step(1'b1, SW, 1'b0, MEMWR,  4'b0000, 9'b000010000, 6'b00_00_00);
        fetch(SW);

        // reset while MEMRD waits also abandons the load
        decode(LW);
        step(1'b0, LW, 1'b1, MEMADR, 4'b0000, 9'b000000010, 6'b10_00_00);
        step(1'b1, LW, 1'b0, MEMRD,  4'b0000, 9'b000010000, 6'b00_00_00);
        fetch(RTYPE);

        repeat (3) @(posedge clk);
        tests++;
        if (sb.size() != 0) begin
            fails++;
            $display("[TB] FAIL drain: got %0d entries left, expected 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
